lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Load/store unit sitting directly downstream of the datapath, between it and the data-memory bus.
- Consumes from the datapath:
  - the effective address (ALU result)
  - the store data (register read port 2)
  - func3
  - the decoded load/store strobes
- Runs a multi-cycle request/grant/response transaction on the bus.
- Returns the sign- or zero-extended read data as the datapath's memory read data.
- Drives a stall that holds the PC and suppresses register write-back until the access completes.

Parameters:
- TIMEOUT_CYCLES, 64: cycles spent in REQ+RESP before the access is aborted with bus_err.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_read  in  1  current instruction is a load.
- mem_write  in  1  current instruction is a store; takes priority if both are high.
- func3  in  3  load/store width and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  32  effective byte address.
- wr_data  in  32  store data, right-aligned.
- rd_data  out  32  extended load result, registered.
- stall  out  1  high while an access is pending; datapath holds PC and RegWrite.
- misalign  out  1  one-cycle pulse: misaligned address or illegal func3.
- bus_err  out  1  one-cycle pulse: bus timeout.
- bus_req  out  1  request valid.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word address {addr[31:2],2'b00}.
- bus_wdata  out  32  lane-replicated store data.
- bus_be  out  4  byte enables.
- bus_gnt  in  1  request accepted this cycle.
- bus_rvalid  in  1  read data valid.
- bus_rdata  in  32  read data word.

Behaviour:
- Clocking and reset: one clock domain, clk. Asynchronous active-low reset rst_n.
- Reset state: state = IDLE; all outputs 0; timeout counter 0.
- Reset asserted mid-transaction: bus_req drops immediately, no completion is reported, and any late bus_gnt or bus_rvalid is ignored.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE, no request (mem_read = mem_write = 0): stall = 0.
- IDLE, request present: stall = 1 combinationally in the same cycle.
- IDLE, legality check (failure sets misalign = 1 for exactly one cycle and moves to DONE with no bus access; rd_data is cleared to 0 on a failed load):
  - Word access requires addr[1:0] = 00.
  - Halfword access requires addr[0] = 0.
  - Loads accept func3 000/001/010/100/101.
  - Stores accept func3 000/001/010.
- IDLE, legal request: latch we, bus_addr, bus_be, bus_wdata, func3 and addr[1:0], then go to REQ.
- Byte enables and write data:
  - SB: be = 0001 << addr[1:0]; wdata = byte replicated x4.
  - SH: be = 0011 or 1100 selected by addr[1]; wdata = halfword replicated x2.
  - SW: be = 1111.
  - Loads: be = 1111, wdata = 0.
- REQ:
  - bus_req = 1; all bus outputs stay stable until bus_gnt.
  - Write granted: go to DONE.
  - Read granted without bus_rvalid: go to RESP.
  - Read granted with bus_rvalid in the same cycle: capture the data and go to DONE.
  - bus_rvalid without bus_gnt is ignored.
- RESP:
  - bus_req = 0.
  - On bus_rvalid: select the lane by the latched addr[1:0], extend per func3, register into rd_data, then go to DONE.
- Timeout:
  - The counter increments each cycle in REQ or RESP and clears in IDLE.
  - When it reaches TIMEOUT_CYCLES: bus_err pulses for one cycle, bus_req drops, rd_data = 0 on reads, and the FSM goes to DONE.
- DONE:
  - stall = 0; rd_data is valid; the datapath commits on this edge.
  - Next state is IDLE unconditionally, so a back-to-back access starts a new transaction on the following instruction.
- Latency: write = 2 + grant wait; read = 3 + grant wait + response wait (cycles in stall).
- rd_data holds its value until the next completed or faulted load; stores leave it unchanged.
- Extension rules:
  - LB/LH sign-extend bit 7/15 of the selected lane.
  - LBU/LHU zero-extend.
  - LW passes the word through.

Test Plan:
- Load, zero wait: LW at addr 0x0000_0010, gnt in the first REQ cycle, rvalid the next cycle with 0xDEADBEEF -> bus_addr = 0x10, be = 1111, stall high 3 cycles, rd_data = 0xDEADBEEF in DONE.
- Byte-lane loads: word 0x80FF_7F01 loaded via LB, LBU, LH and LHU.
  - LB addr 0x..3 -> 0xFFFFFF80.
  - LBU addr 0x..3 -> 0x00000080.
  - LH addr 0x..2 -> 0xFFFF80FF.
  - LHU addr 0x..0 -> 0x00007F01.
- Stores: wr_data 0x1234_56AB.
  - SB addr 0x..1 -> be = 0010, wdata = 0xABABABAB.
  - SH addr 0x..2 -> be = 1100, wdata = 0x56AB56AB.
  - In each case, the write enters DONE on gnt with no RESP state.
- Misalign: LW at addr 0x..2, and separately a store with func3 = 100 -> misalign pulses 1 cycle, bus_req never asserts, stall is 1 cycle total, rd_data = 0 for the load.
- Timeout: TIMEOUT_CYCLES = 4, gnt never asserted -> bus_err pulses on cycle 4 of REQ, bus_req drops, DONE follows, stall releases.
- Reset mid-RESP: assert rst_n low while waiting for rvalid -> all outputs are 0 asynchronously; an rvalid after reset release leaves rd_data = 0 and state = IDLE.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: turns one datapath load or store into a request/grant/response
// transaction on the data-memory bus, and stalls the pipeline until the access completes.
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;
  logic [2:0]         func3_q, func3_d;
  logic [1:0]         off_q, off_d;
  logic [31:0]        rd_data_q, rd_data_d;

  logic               legal;
  logic               timeout;
  logic [7:0]         lane_b;
  logic [15:0]        lane_h;
  logic [31:0]        load_ext;

  // Width/sign legality: stores accept only B/H/W, and each width has its own alignment.
  always_comb begin
    case (func3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~addr[0];
      3'b010:  legal = (addr[1:0] == 2'b00);
      3'b100:  legal = ~mem_write;
      3'b101:  legal = ~mem_write & ~addr[0];
      default: legal = 1'b0;
    endcase
  end

  // Lane select uses the offset latched at request time, not the live address.
  always_comb begin
    case (off_q)
      2'd0:    lane_b = bus_rdata[7:0];
      2'd1:    lane_b = bus_rdata[15:8];
      2'd2:    lane_b = bus_rdata[23:16];
      default: lane_b = bus_rdata[31:24];
    endcase
    lane_h = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (func3_q)
      3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_ext = {24'h0, lane_b};
      3'b101:  load_ext = {16'h0, lane_h};
      default: load_ext = bus_rdata;
    endcase
  end

  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    // NOTE: every variable gets a default here so no path through the case infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    func3_d   = func3_q;
    off_d     = off_q;
    rd_data_d = rd_data_q;
    stall     = 1'b0;
    misalign  = 1'b0;
    bus_err   = 1'b0;
    bus_req   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (mem_read || mem_write) begin
          stall = 1'b1;
          if (!legal) begin
            misalign = 1'b1;
            state_d  = DONE;
            if (!mem_write) rd_data_d = '0;
          end else begin
            we_d    = mem_write;
            addr_d  = {addr[31:2], 2'b00};
            func3_d = func3;
            off_d   = addr[1:0];
            state_d = REQ;
            if (mem_write) begin
              case (func3[1:0])
                2'b00: begin
                  be_d    = 4'b0001 << addr[1:0];
                  wdata_d = {4{wr_data[7:0]}};
                end
                2'b01: begin
                  be_d    = addr[1] ? 4'b1100 : 4'b0011;
                  wdata_d = {2{wr_data[15:0]}};
                end
                default: begin
                  be_d    = 4'b1111;
                  wdata_d = wr_data;
                end
              endcase
            end else begin
              be_d    = 4'b1111;
              wdata_d = '0;
            end
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (timeout) begin
          bus_err = 1'b1;
          state_d = DONE;
          if (!we_q) rd_data_d = '0;
        end else begin
          bus_req = 1'b1;
          if (bus_gnt) begin
            if (we_q) begin
              state_d = DONE;
            end else if (bus_rvalid) begin
              rd_data_d = load_ext;
              state_d   = DONE;
            end else begin
              state_d = RESP;
            end
          end
        end
      end
      RESP: begin
        stall = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (timeout) begin
          bus_err   = 1'b1;
          rd_data_d = '0;
          state_d   = DONE;
        end else if (bus_rvalid) begin
          rd_data_d = load_ext;
          state_d   = DONE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      func3_q   <= '0;
      off_q     <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      func3_q   <= func3_d;
      off_q     <= off_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_be    = be_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: loads of every width, stores, alignment faults,
// bus timeout and reset in the middle of a read.
module tb_lsu_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  func3;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        stall;
  logic        misalign;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int n_cmp = 0;
  int n_err = 0;

  lsu_mem_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .func3      (func3),
    .addr       (addr),
    .wr_data    (wr_data),
    .rd_data    (rd_data),
    .stall      (stall),
    .misalign   (misalign),
    .bus_err    (bus_err),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_be     (bus_be),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Load with grant in the first REQ cycle; rvalid either with the grant or one cycle later.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] word, input bit same, input logic [31:0] exp);
    mem_read = 1'b1; func3 = f3; addr = a;
    sample();
    check({tag, " idle stall"}, 32'(stall), 32'd1);
    check({tag, " idle req"}, 32'(bus_req), 32'd0);
    tick();
    bus_gnt = 1'b1; bus_rvalid = same; bus_rdata = word;
    sample();
    check({tag, " req"}, 32'(bus_req), 32'd1);
    check({tag, " addr"}, bus_addr, {a[31:2], 2'b00});
    check({tag, " be"}, 32'(bus_be), 32'hf);
    check({tag, " we"}, 32'(bus_we), 32'd0);
    tick();
    bus_gnt = 1'b0;
    if (!same) begin
      bus_rvalid = 1'b1;
      sample();
      check({tag, " resp stall"}, 32'(stall), 32'd1);
      check({tag, " resp req"}, 32'(bus_req), 32'd0);
      tick();
    end
    bus_rvalid = 1'b0; bus_rdata = 32'h0;
    sample();
    check({tag, " done stall"}, 32'(stall), 32'd0);
    check({tag, " rd_data"}, rd_data, exp);
    mem_read = 1'b0;
    tick();
  endtask

  // Store with a chosen number of grant wait cycles; bus outputs must hold while waiting.
  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int waits,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input logic [31:0] rd_keep);
    mem_write = 1'b1; func3 = f3; addr = a; wr_data = wd;
    sample();
    check({tag, " idle stall"}, 32'(stall), 32'd1);
    tick();
    for (int i = 0; i <= waits; i++) begin
      bus_gnt = (i == waits);
      sample();
      check({tag, " req"}, 32'(bus_req), 32'd1);
      check({tag, " we"}, 32'(bus_we), 32'd1);
      check({tag, " addr"}, bus_addr, {a[31:2], 2'b00});
      check({tag, " be"}, 32'(bus_be), 32'(exp_be));
      check({tag, " wdata"}, bus_wdata, exp_wdata);
      tick();
    end
    bus_gnt = 1'b0;
    sample();
    check({tag, " done stall"}, 32'(stall), 32'd0);
    check({tag, " done req"}, 32'(bus_req), 32'd0);
    check({tag, " rd_data kept"}, rd_data, rd_keep);
    mem_write = 1'b0;
    tick();
  endtask

  // Illegal access: one-cycle misalign in IDLE, then DONE without touching the bus.
  task automatic do_fault(input string tag, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] exp_rd);
    mem_read = ~wr; mem_write = wr; func3 = f3; addr = a; wr_data = 32'hFFFF_FFFF;
    sample();
    check({tag, " misalign"}, 32'(misalign), 32'd1);
    check({tag, " stall"}, 32'(stall), 32'd1);
    check({tag, " req"}, 32'(bus_req), 32'd0);
    tick();
    sample();
    check({tag, " done misalign"}, 32'(misalign), 32'd0);
    check({tag, " done stall"}, 32'(stall), 32'd0);
    check({tag, " done req"}, 32'(bus_req), 32'd0);
    check({tag, " rd_data"}, rd_data, exp_rd);
    mem_read = 1'b0; mem_write = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; func3 = 3'b0; addr = 32'h0;
    wr_data = 32'h0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    #12;
    check("rst stall", 32'(stall), 32'd0);
    check("rst rd_data", rd_data, 32'h0);
    check("rst bus_req", 32'(bus_req), 32'd0);
    check("rst bus_be", 32'(bus_be), 32'h0);
    check("rst bus_addr", bus_addr, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    do_load("lw0", 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF);
    do_load("lb3", 3'b000, 32'h0000_0103, 32'h80FF_7F01, 1'b0, 32'hFFFF_FF80);
    do_load("lbu3", 3'b100, 32'h0000_0103, 32'h80FF_7F01, 1'b1, 32'h0000_0080);
    do_load("lh2", 3'b001, 32'h0000_0102, 32'h80FF_7F01, 1'b0, 32'hFFFF_80FF);
    do_load("lhu0", 3'b101, 32'h0000_0100, 32'h80FF_7F01, 1'b1, 32'h0000_7F01);

    do_store("sb1", 3'b000, 32'h0000_0201, 32'h1234_56AB, 0, 4'b0010, 32'hABAB_ABAB, 32'h0000_7F01);
    do_store("sh2", 3'b001, 32'h0000_0202, 32'h1234_56AB, 2, 4'b1100, 32'h56AB_56AB, 32'h0000_7F01);
    do_store("sw0", 3'b010, 32'h0000_0204, 32'h1234_56AB, 0, 4'b1111, 32'h1234_56AB, 32'h0000_7F01);

    do_fault("st f3=100", 1'b1, 3'b100, 32'h0000_0300, 32'h0000_7F01);

    // Timeout: grant never comes; fourth REQ cycle aborts.
    mem_read = 1'b1; func3 = 3'b010; addr = 32'h0000_0020;
    tick();
    for (int i = 1; i <= 3; i++) begin
      sample();
      check("to req", 32'(bus_req), 32'd1);
      check("to no err", 32'(bus_err), 32'd0);
      tick();
    end
    sample();
    check("to err", 32'(bus_err), 32'd1);
    check("to req drop", 32'(bus_req), 32'd0);
    check("to stall", 32'(stall), 32'd1);
    tick();
    sample();
    check("to done err", 32'(bus_err), 32'd0);
    check("to done stall", 32'(stall), 32'd0);
    check("to rd_data", rd_data, 32'h0);
    mem_read = 1'b0;
    tick();

    do_load("lw1", 3'b010, 32'h0000_0040, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D);
    do_fault("lw mis", 1'b0, 3'b010, 32'h0000_0012, 32'h0);
    do_load("lw2", 3'b010, 32'h0000_0044, 32'h1111_2222, 1'b1, 32'h1111_2222);

    // Reset while in RESP; the late rvalid after release must be ignored.
    mem_read = 1'b1; func3 = 3'b010; addr = 32'h0000_0048;
    tick();
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    #1;
    rst_n = 1'b0; mem_read = 1'b0;
    #1;
    check("mid rst stall", 32'(stall), 32'd0);
    check("mid rst req", 32'(bus_req), 32'd0);
    check("mid rst rd_data", rd_data, 32'h0);
    check("mid rst be", 32'(bus_be), 32'h0);
    check("mid rst addr", bus_addr, 32'h0);
    tick();
    rst_n = 1'b1;
    bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    sample();
    check("post rst stall", 32'(stall), 32'd0);
    tick();
    bus_rvalid = 1'b0;
    sample();
    check("post rst rd_data", rd_data, 32'h0);
    check("post rst stall2", 32'(stall), 32'd0);
    check("post rst req", 32'(bus_req), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
